ifu: RTL and testbench

Instruction fetch unit: the producer side of the instruction word consumed by the decoder. It holds the PC, issues one word-aligned read per instruction on a valid/ready memory port, and presents the returned word plus its PC to the decoder on a valid/ready handshake. It then waits for the execute stage to supply the next PC. The block is strictly one-instruction-in-flight (multi-cycle core) and stops fetching on halt or fetch error.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu.sv | 155 +++++++++++++++
 tb/tb_ifu.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: reset PC, FSM state
// encoding and fetch error codes.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_NPC  = 3'd4,
        S_HALT = 3'd5
    } ifu_state_t;

    localparam logic [1:0] FE_NONE     = 2'd0;
    localparam logic [1:0] FE_ACCESS   = 2'd1;
    localparam logic [1:0] FE_MISALIGN = 2'd2;

    // True when the low address bits describe a word-aligned address.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one instruction in flight. Issues a word read for
// pc, hands the returned word to the decoder, then waits for the next PC from
// execute. Stops for good on halt or on a fetch error until reset.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,

    input  logic        npc_valid,
    input  logic [31:0] npc,

    input  logic        halt,
    output logic        halted,
    output logic [1:0]  fetch_err,
    output logic [31:0] fetch_cnt
);

    ifu_state_t  state;
    ifu_state_t  state_nxt;
    logic [31:0] pc;
    logic        halt_pend;

    logic        pc_load;
    logic        inst_load;
    logic        cnt_inc;
    logic        err_load;
    logic [1:0]  err_code;
    logic        pend_set;

    // Next-state and register-update decisions for the fetch sequence.
    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        inst_load = 1'b0;
        cnt_inc   = 1'b0;
        err_load  = 1'b0;
        err_code  = FE_NONE;
        pend_set  = 1'b0;

        unique case (state)
            S_BOOT: begin
                state_nxt = halt ? S_HALT : S_REQ;
            end

            S_REQ: begin
                if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                end else if (halt) begin
                    state_nxt = S_HALT;
                end
            end

            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        err_load  = 1'b1;
                        err_code  = FE_ACCESS;
                        state_nxt = S_HALT;
                    end else if (halt_pend || halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        inst_load = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (halt) begin
                    pend_set = 1'b1;
                end
            end

            S_HOLD: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (inst_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = S_NPC;
                end
            end

            S_NPC: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (npc_valid) begin
                    if (!is_word_aligned(npc[1:0])) begin
                        err_load  = 1'b1;
                        err_code  = FE_MISALIGN;
                        state_nxt = S_HALT;
                    end else begin
                        pc_load   = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    // State, PC, instruction latch, counters and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            inst      <= 32'd0;
            inst_pc   <= 32'd0;
            fetch_err <= FE_NONE;
            fetch_cnt <= 32'd0;
            halt_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pc_load) begin
                pc <= npc;
            end
            if (inst_load) begin
                inst    <= imem_resp_data;
                inst_pc <= pc;
            end
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (err_load && (fetch_err == FE_NONE)) begin
                fetch_err <= err_code;
            end
            if (pend_set) begin
                halt_pend <= 1'b1;
            end
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a transaction-level model of the fetch loop
// is compared against the DUT every cycle, with directed scenarios pinned by
// literal expectations followed by randomized traffic.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        npc_valid;
    logic [31:0] npc;
    logic        halt;
    logic        halted;
    logic [1:0]  fetch_err;
    logic [31:0] fetch_cnt;

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .npc_valid       (npc_valid),
        .npc             (npc),
        .halt            (halt),
        .halted          (halted),
        .fetch_err       (fetch_err),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Where the single in-flight instruction currently is, from the bench's view.
    typedef enum int {
        MP_START,
        MP_ASK,
        MP_FLIGHT,
        MP_SHOW,
        MP_NEXT,
        MP_STOP
    } mphase_t;

    mphase_t     m_ph;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic [1:0]  m_err;
    logic [31:0] m_cnt;
    logic        m_pend;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic rr, input logic rv, input logic rerr,
                              input logic [31:0] rdata, input logic ir, input logic nv,
                              input logic [31:0] n, input logic h);
        if (!rn) begin
            m_ph      = MP_START;
            m_pc      = RST_PC;
            m_inst    = 32'd0;
            m_inst_pc = 32'd0;
            m_err     = 2'd0;
            m_cnt     = 32'd0;
            m_pend    = 1'b0;
        end else begin
            case (m_ph)
                MP_START:  m_ph = h ? MP_STOP : MP_ASK;
                MP_ASK: begin
                    if (rr) m_ph = MP_FLIGHT;
                    else if (h) m_ph = MP_STOP;
                end
                MP_FLIGHT: begin
                    if (rv) begin
                        if (rerr) begin
                            if (m_err == 2'd0) m_err = 2'd1;
                            m_ph = MP_STOP;
                        end else if (m_pend || h) begin
                            m_ph = MP_STOP;
                        end else begin
                            m_inst    = rdata;
                            m_inst_pc = m_pc;
                            m_ph      = MP_SHOW;
                        end
                    end else if (h) begin
                        m_pend = 1'b1;
                    end
                end
                MP_SHOW: begin
                    if (h) m_ph = MP_STOP;
                    else if (ir) begin
                        m_cnt = m_cnt + 32'd1;
                        m_ph  = MP_NEXT;
                    end
                end
                MP_NEXT: begin
                    if (h) m_ph = MP_STOP;
                    else if (nv) begin
                        if (n[1:0] != 2'b00) begin
                            if (m_err == 2'd0) m_err = 2'd2;
                            m_ph = MP_STOP;
                        end else begin
                            m_pc = n;
                            m_ph = MP_ASK;
                        end
                    end
                end
                default: m_ph = MP_STOP;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic rr, input logic rv, input logic rerr,
                                 input logic [31:0] rdata, input logic ir, input logic nv,
                                 input logic [31:0] n, input logic h);
        rst_n           = rn;
        imem_req_ready  = rr;
        imem_resp_valid = rv;
        imem_resp_err   = rerr;
        imem_resp_data  = rdata;
        inst_ready      = ir;
        npc_valid       = nv;
        npc             = n;
        halt            = h;
        model_step(rn, rr, rv, rerr, rdata, ir, nv, n, h);
    endtask

    task automatic checkOutput();
        check32("req_valid",  32'(imem_req_valid), 32'(m_ph == MP_ASK));
        check32("req_addr",   imem_req_addr, m_pc);
        check32("inst_valid", 32'(inst_valid), 32'(m_ph == MP_SHOW));
        check32("inst",       inst, m_inst);
        check32("inst_pc",    inst_pc, m_inst_pc);
        check32("halted",     32'(halted), 32'(m_ph == MP_STOP));
        check32("fetch_err",  32'(fetch_err), 32'(m_err));
        check32("fetch_cnt",  fetch_cnt, m_cnt);
    endtask

    task automatic step(input logic rn, input logic rr, input logic rv, input logic rerr,
                        input logic [31:0] rdata, input logic ir, input logic nv,
                        input logic [31:0] n, input logic h);
        applyStimulus(rn, rr, rv, rerr, rdata, ir, nv, n, h);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    // Ideal memory and decoder; optional error response and halt in the next-PC phase.
    task automatic run_fetch(input int cycles, input logic [31:0] data, input logic rerr,
                             input logic [31:0] nxt, input logic halt_at_next);
        for (int k = 0; k < cycles; k++) begin
            step(1'b1, 1'b1, (m_ph == MP_FLIGHT), rerr, data, 1'b1, 1'b1, nxt,
                 halt_at_next && (m_ph == MP_NEXT));
        end
    endtask

    // Fetch one word and leave it sitting at the decoder (inst_ready held low).
    task automatic reach_hold(input logic [31:0] data);
        for (int k = 0; k < 10 && m_ph != MP_SHOW; k++) begin
            step(1'b1, 1'b1, (m_ph == MP_FLIGHT), 1'b0, data, 1'b0, 1'b0, 32'd0, 1'b0);
        end
        check32("reached_hold", 32'(m_ph == MP_SHOW), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] nx;
        int          fl;

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        imem_resp_data = 32'd0; inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'd0; halt = 1'b0;
        m_ph = MP_START; m_pc = RST_PC; m_inst = 32'd0; m_inst_pc = 32'd0;
        m_err = 2'd0; m_cnt = 32'd0; m_pend = 1'b0;
        @(negedge clk);

        $display("[TB] scenario: basic fetch loop");
        do_reset();
        check32("rst_req_valid",  32'(imem_req_valid), 32'd0);
        check32("rst_inst_valid", 32'(inst_valid), 32'd0);
        check32("rst_halted",     32'(halted), 32'd0);
        check32("rst_fetch_cnt",  fetch_cnt, 32'd0);
        check32("rst_fetch_err",  32'(fetch_err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, (m_ph == MP_FLIGHT), 1'b0, 32'h0050_0093, 1'b1, 1'b1,
                 32'h8000_0004, 1'b0);
            if (k == 0) begin
                check32("c1_req_valid", 32'(imem_req_valid), 32'd1);
                check32("c1_req_addr",  imem_req_addr, 32'h8000_0000);
            end
            if (k == 2) begin
                check32("c3_inst_valid", 32'(inst_valid), 32'd1);
                check32("c3_inst",       inst, 32'h0050_0093);
                check32("c3_inst_pc",    inst_pc, 32'h8000_0000);
            end
            if (k == 4) begin
                check32("c5_req_valid", 32'(imem_req_valid), 32'd1);
                check32("c5_req_addr",  imem_req_addr, 32'h8000_0004);
                check32("c5_fetch_cnt", fetch_cnt, 32'd1);
            end
        end

        $display("[TB] scenario: backpressure");
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, (k >= 4), (m_ph == MP_FLIGHT), 1'b0, 32'hDEAD_BEEF, (k >= 11), 1'b0,
                 32'd0, 1'b0);
        end
        check32("bp_fetch_cnt",  fetch_cnt, 32'd1);
        check32("bp_req_valid",  32'(imem_req_valid), 32'd0);
        check32("bp_inst_valid", 32'(inst_valid), 32'd0);

        $display("[TB] scenario: access fault on first fetch");
        do_reset();
        run_fetch(6, 32'h1234_5678, 1'b1, 32'h8000_0004, 1'b0);
        check32("af_halted",    32'(halted), 32'd1);
        check32("af_fetch_err", 32'(fetch_err), 32'd1);
        check32("af_fetch_cnt", fetch_cnt, 32'd0);

        $display("[TB] scenario: misaligned next pc");
        do_reset();
        run_fetch(8, 32'h0000_0013, 1'b0, 32'h8000_0006, 1'b0);
        check32("mis_halted",    32'(halted), 32'd1);
        check32("mis_fetch_err", 32'(fetch_err), 32'd2);
        check32("mis_req_valid", 32'(imem_req_valid), 32'd0);

        $display("[TB] scenario: halt with npc_valid");
        do_reset();
        run_fetch(8, 32'h0000_0013, 1'b0, 32'h8000_0004, 1'b1);
        check32("hn_halted",    32'(halted), 32'd1);
        check32("hn_fetch_err", 32'(fetch_err), 32'd0);
        check32("hn_fetch_cnt", fetch_cnt, 32'd1);
        check32("hn_req_valid", 32'(imem_req_valid), 32'd0);

        $display("[TB] scenario: halt while waiting for memory");
        do_reset();
        fl = 0;
        for (int k = 0; k < 8; k++) begin
            logic f;
            f = (m_ph == MP_FLIGHT);
            step(1'b1, 1'b1, f && (fl > 0), 1'b0, 32'hCAFE_0001, 1'b1, 1'b1, 32'h8000_0004,
                 f && (fl == 0));
            if (f) fl++;
        end
        check32("hw_halted",     32'(halted), 32'd1);
        check32("hw_inst_valid", 32'(inst_valid), 32'd0);
        check32("hw_fetch_cnt",  fetch_cnt, 32'd0);

        $display("[TB] scenario: fetch counter wrap");
        do_reset();
        reach_hold(32'h0000_0093);
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        release dut.fetch_cnt;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("wrap_fetch_cnt", fetch_cnt, 32'd0);

        $display("[TB] scenario: reset while holding an instruction");
        do_reset();
        run_fetch(5, 32'h0000_0013, 1'b0, 32'h8000_0100, 1'b0);
        reach_hold(32'h0000_0093);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        check32("rh_inst_valid", 32'(inst_valid), 32'd0);
        check32("rh_fetch_cnt",  fetch_cnt, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        check32("rh_req_valid",  32'(imem_req_valid), 32'd1);
        check32("rh_req_addr",   imem_req_addr, RST_PC);

        $display("[TB] scenario: randomized traffic");
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (m_ph == MP_STOP && ($urandom % 4) == 0) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            end else begin
                r  = $urandom;
                nx = r & 32'hFFFF_FFFC;
                if (($urandom % 12) == 0) nx = nx | (32'd1 + (r % 3));
                step(1'b1,
                     ($urandom % 2) == 0,
                     (m_ph == MP_FLIGHT) ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                     ($urandom % 16) == 0,
                     $urandom,
                     ($urandom % 2) == 0,
                     ($urandom % 2) == 0,
                     nx,
                     ($urandom % 40) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
